ksa_pipe_sub: RTL

//   Pipelined Kogge-Stone parallel-prefix subtractor: {bout,diff} = a - b - bin.

---
 rtl/ksa_pipe_sub_if.sv | 30 +++
 rtl/ksa_pipe_sub.sv | 105 ++++++++++
 2 files changed

// File: rtl/ksa_pipe_sub_if.sv
// ksa_pipe_sub_if: operand/result handshake bundle for the pipelined KSA subtractor.
//   in_valid/in_ready carry a, b, bin into the pipe; out_valid/out_ready carry
//   diff, bout out of it.
//   master: the side that supplies operands and consumes results.
//   slave : the subtractor itself.
// Handshake: a transfer happens on a rising clock edge where valid and ready are
//   both high; the sender holds its payload stable while valid & ~ready.
interface ksa_pipe_sub_if #(
    parameter int BITS = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] diff;
    logic            bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/ksa_pipe_sub.sv
// ksa_pipe_sub: pipelined Kogge-Stone subtractor, {bout,diff} = a - b - bin.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ksa_pipe_sub_if slave (in_valid/in_ready/a/b/bin in,
//            out_valid/out_ready/diff/bout out)
// Structure: stage 0 registers generate/propagate, stages 1..LEVELS each
//   register one prefix level, then an output register holds diff/bout.
//   Every stage advances together when the output is free or being taken.
module ksa_pipe_sub #(
    parameter int BITS   = 16,
    parameter int LEVELS = 4
) (
    input logic          clk,
    input logic          rst_n,
    ksa_pipe_sub_if.slave bus
);
    generate
        if (LEVELS != $clog2(BITS)) begin : g_bad_levels
            $error("ksa_pipe_sub: LEVELS must equal $clog2(BITS)");
        end
    endgenerate

    localparam logic [BITS:0] ONES = '1;

    // Prefix vectors are BITS+1 wide: bit 0 is the carry-in (~bin) modelled as
    // a generate with no propagate, bit i+1 is operand bit i. After the last
    // level, g[i] is the carry into operand bit i.
    logic [BITS:0]   g_q  [0:LEVELS];
    logic [BITS:0]   g_d  [0:LEVELS];
    logic [BITS:0]   p_q  [0:LEVELS];
    logic [BITS:0]   p_d  [0:LEVELS];
    logic [BITS-1:0] po_q [0:LEVELS];
    logic [BITS-1:0] po_d [0:LEVELS];
    logic            v_q  [0:LEVELS];
    logic            v_d  [0:LEVELS];

    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            advance;

    always_comb begin
        advance = bus.out_ready | ~out_valid_q;

        for (int k = 0; k <= LEVELS; k++) begin
            g_d[k]  = g_q[k];
            p_d[k]  = p_q[k];
            po_d[k] = po_q[k];
            v_d[k]  = v_q[k];
        end
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;

        if (advance) begin
            // a - b - bin == a + ~b + ~bin
            v_d[0]  = bus.in_valid;
            g_d[0]  = {bus.a & ~bus.b, ~bus.bin};
            p_d[0]  = {bus.a ^ ~bus.b, 1'b0};
            po_d[0] = bus.a ^ ~bus.b;

            for (int k = 1; k <= LEVELS; k++) begin
                // Low 'span' bits have no partner below them and pass through.
                g_d[k]  = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k - 1))));
                p_d[k]  = p_q[k-1] & ((p_q[k-1] << (1 << (k - 1))) | ~(ONES << (1 << (k - 1))));
                po_d[k] = po_q[k-1];
                v_d[k]  = v_q[k-1];
            end

            out_valid_d = v_q[LEVELS];
            diff_d      = po_q[LEVELS] ^ g_q[LEVELS][BITS-1:0];
            // The top node spans bits 1..BITS; fold in bit 0 (carry-in) for cout.
            bout_d      = ~(g_q[LEVELS][BITS] | (p_q[LEVELS][BITS] & g_q[LEVELS][0]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k]  <= '0;
                p_q[k]  <= '0;
                po_q[k] <= '0;
                v_q[k]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            for (int k = 0; k <= LEVELS; k++) begin
                g_q[k]  <= g_d[k];
                p_q[k]  <= p_d[k];
                po_q[k] <= po_d[k];
                v_q[k]  <= v_d[k];
            end
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule
